// File: rtl/byte_unpack_tx.sv
// byte_unpack_tx: serializes a DATA_WIDTH word into bytes over a valid/ready pair.
// Optional feature macro: MSB_FIRST_EN (most significant byte first when defined).
module byte_unpack_tx #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic [7:0]            byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [SEL_WIDTH-1:0]  byte_sel,
  output logic                  byte_last,
  input  logic                  abort
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

`ifdef MSB_FIRST_EN
  localparam logic [SEL_WIDTH-1:0] START_LANE = SEL_WIDTH'(LANES - 1);
  localparam logic [SEL_WIDTH-1:0] LAST_LANE  = SEL_WIDTH'(0);
`else
  localparam logic [SEL_WIDTH-1:0] START_LANE = SEL_WIDTH'(0);
  localparam logic [SEL_WIDTH-1:0] LAST_LANE  = SEL_WIDTH'(LANES - 1);
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] hold;
  logic [SEL_WIDTH-1:0]  sel_next;

  // Byte lane of a word addressed by a lane index.
  function automatic logic [7:0] lane_byte(input logic [DATA_WIDTH-1:0] w,
                                           input logic [SEL_WIDTH-1:0]  s);
    return w[{s, 3'b000} +: 8];
  endfunction

  // Next lane in the configured serialization order.
  always_comb begin
    sel_next = byte_sel;
`ifdef MSB_FIRST_EN
    sel_next = byte_sel - SEL_WIDTH'(1);
`else
    sel_next = byte_sel + SEL_WIDTH'(1);
`endif
  end

  // Accept a word when idle or when the last byte leaves; held off in reset and on abort.
  assign word_ready = rst && !abort &&
                      ((state == IDLE) || (byte_last && byte_ready));

  // Holding register, lane pointer and registered byte-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold       <= '0;
      byte_sel   <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      hold       <= '0;
      byte_sel   <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
    end else if (word_valid && word_ready) begin
      // Covers both the idle capture and back-to-back reload on the last byte.
      state      <= SEND;
      hold       <= word_in;
      byte_sel   <= START_LANE;
      byte_out   <= lane_byte(word_in, START_LANE);
      byte_valid <= 1'b1;
      byte_last  <= (START_LANE == LAST_LANE);
    end else if ((state == SEND) && byte_ready) begin
      if (byte_last) begin
        state      <= IDLE;
        hold       <= '0;
        byte_sel   <= '0;
        byte_out   <= '0;
        byte_valid <= 1'b0;
        byte_last  <= 1'b0;
      end else begin
        byte_sel   <= sel_next;
        byte_out   <= lane_byte(hold, sel_next);
        byte_last  <= (sel_next == LAST_LANE);
      end
    end
  end

endmodule

// File: tb/tb_byte_unpack_tx.sv
// tb_byte_unpack_tx: directed vectors for byte_unpack_tx (follows MSB_FIRST_EN if defined).
module tb_byte_unpack_tx;

  localparam int unsigned DW    = 32;
  localparam int unsigned SW    = 2;
  localparam int unsigned LANES = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready = 1'b0;
  logic [SW-1:0] byte_sel;
  logic          byte_last;
  logic          abort = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int xfers = 0;
  int base;

  byte_unpack_tx #(.DATA_WIDTH(DW), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .byte_sel(byte_sel), .byte_last(byte_last),
    .abort(abort)
  );

  always #5 clk = ~clk;

  // Count byte transfers seen at rising edges.
  always @(posedge clk) if (rst && byte_valid && byte_ready) xfers++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Lane emitted at position k of a word.
  function automatic int lane(input int k);
`ifdef MSB_FIRST_EN
    return LANES - 1 - k;
`else
    return k;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input logic [DW-1:0] w, input int k);
    logic [DW-1:0] t;
    t = w >> (8 * lane(k));
    return t[7:0];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_byte(input string tag, input logic [DW-1:0] w, input int k);
    check({tag, "_valid"}, 32'(byte_valid), 32'd1);
    check({tag, "_out"},   32'(byte_out),   32'(exp_byte(w, k)));
    check({tag, "_sel"},   32'(byte_sel),   32'(lane(k)));
    check({tag, "_last"},  32'(byte_last),  32'(k == LANES - 1));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_out"},   32'(byte_out),   32'd0);
    check({tag, "_sel"},   32'(byte_sel),   32'd0);
    check({tag, "_last"},  32'(byte_last),  32'd0);
  endtask

  // Present one word for a single cycle from IDLE.
  task automatic load(input logic [DW-1:0] w);
    word_in = w;
    word_valid = 1'b1;
    #1;
    check("load_ready", 32'(word_ready), 32'd1);
    tick();
    word_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_ready", 32'(word_ready), 32'd0);
    check_idle("rst");
    #9;
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(word_ready), 32'd1);
    tick();

    // Basic serialization, byte_ready tied high
    byte_ready = 1'b1;
    base = xfers;
    load(32'hA1B2C3D4);
    for (int k = 0; k < LANES; k++) begin
      #1;
      check_byte("basic", 32'hA1B2C3D4, k);
      tick();
    end
    check_idle("basic_end");
    check("basic_cnt", 32'(xfers - base), 32'd4);

    // Backpressure on byte position 1
    base = xfers;
    load(32'h11223344);
    #1;
    check_byte("bp0", 32'h11223344, 0);
    tick();
    byte_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_byte("bp_hold", 32'h11223344, 1);
      tick();
    end
    byte_ready = 1'b1;
    for (int k = 1; k < LANES; k++) begin
      #1;
      check_byte("bp", 32'h11223344, k);
      tick();
    end
    check_idle("bp_end");
    check("bp_cnt", 32'(xfers - base), 32'd4);

    // Back-to-back words with word_valid held
    base = xfers;
    word_in = 32'h01020304;
    word_valid = 1'b1;
    tick();
    word_in = 32'h05060708;
    for (int k = 0; k < LANES; k++) begin
      #1;
      check_byte("b2b_w1", 32'h01020304, k);
      check("b2b_w1_ready", 32'(word_ready), 32'(k == LANES - 1));
      tick();
    end
    word_valid = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      #1;
      check_byte("b2b_w2", 32'h05060708, k);
      check("b2b_w2_ready", 32'(word_ready), 32'(k == LANES - 1));
      tick();
    end
    check_idle("b2b_end");
    check("b2b_cnt", 32'(xfers - base), 32'd8);

    // Abort at byte position 2, with a competing word offered
    load(32'hDEADBEEF);
    tick();
    tick();
    #1;
    check_byte("abort_pre", 32'hDEADBEEF, 2);
    abort = 1'b1;
    word_in = 32'h55667788;
    word_valid = 1'b1;
    #1;
    check("abort_ready", 32'(word_ready), 32'd0);
    tick();
    abort = 1'b0;
    word_valid = 1'b0;
    #1;
    check_idle("abort_post");
    check("abort_post_ready", 32'(word_ready), 32'd1);
    load(32'hCAFEBABE);
    #1;
    check_byte("abort_next", 32'hCAFEBABE, 0);
    for (int k = 0; k < LANES; k++) tick();
    #1;
    check_idle("abort_next_end");

    // Abort in IDLE beats a word transfer
    word_in = 32'h12345678;
    word_valid = 1'b1;
    abort = 1'b1;
    #1;
    check("idle_abort_ready", 32'(word_ready), 32'd0);
    tick();
    abort = 1'b0;
    word_valid = 1'b0;
    #1;
    check_idle("idle_abort");

    // Asynchronous reset mid-word
    base = xfers;
    load(32'h9ABCDEF0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    check_idle("arst");
    check("arst_ready", 32'(word_ready), 32'd0);
    tick();
    tick();
    #3;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      check_idle("arst_after");
    end
    check("arst_cnt", 32'(xfers - base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
